// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/exec/mem/wb control
// with memory-ack timeouts, terminal halt/fault and a retire counter.
module instr_sequencer #(
  parameter int WIDTH       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] instr,
  input  logic             cond_flag,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             ir_wr_en,
  output logic             pc_wr_en,
  output logic [1:0]       pc_mux_sel,
  output logic             reg_wr_en,
  output logic             halted,
  output logic             fault,
  output logic [2:0]       state,
  output logic [WIDTH-1:0] retired
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;

  localparam logic [7:0] T_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    C_ALU, C_BR, C_JAL, C_LD, C_ST, C_HLT, C_BAD
  } cls_t;

  logic [2:0] st, st_nx;
  cls_t       cls, cls_dec;
  logic [7:0] wcnt;
  logic       unused_bits;

  assign unused_bits = ^instr[WIDTH-5:0];
  assign state       = st;

  always_comb begin
    cls_dec = C_BAD;
    unique case (instr[31:28])
      4'b1100, 4'b1101,
      4'b1000, 4'b1001: cls_dec = C_ALU;
      4'b0010:          cls_dec = C_BR;
      4'b0110:          cls_dec = C_JAL;
      4'b0111:          cls_dec = C_LD;
      4'b0011:          cls_dec = C_ST;
      4'b1111:          cls_dec = C_HLT;
      default:          cls_dec = C_BAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) st <= S_FETCH;
    else          st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      S_FETCH: begin
        if (imem_ack)            st_nx = S_DECODE;
        else if (wcnt == T_LAST) st_nx = S_FAULT;
      end
      S_DECODE: begin
        unique case (cls_dec)
          C_ALU, C_BR, C_JAL: st_nx = S_EXEC;
          C_LD, C_ST:         st_nx = S_MEM;
          C_HLT:              st_nx = S_HALT;
          default:            st_nx = S_FAULT;
        endcase
      end
      S_EXEC: st_nx = S_FETCH;
      S_MEM: begin
        if (dmem_ack)
          st_nx = (cls == C_ST) ? S_FETCH : S_WB;
        else if (wcnt == T_LAST)
          st_nx = S_FAULT;
      end
      S_WB:    st_nx = S_FETCH;
      S_HALT:  st_nx = S_HALT;
      S_FAULT: st_nx = S_FAULT;
      default: st_nx = S_FAULT;
    endcase
  end

  // class is captured while leaving DECODE so later instr edits are inert
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cls  <= C_ALU;
      wcnt <= '0;
    end else begin
      if (st == S_DECODE) cls <= cls_dec;
      if (st_nx != st && (st_nx == S_FETCH || st_nx == S_MEM))
        wcnt <= '0;
      else if ((st == S_FETCH && !imem_ack) ||
               (st == S_MEM && !dmem_ack))
        wcnt <= wcnt + 8'd1;
    end
  end

  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_wr_en   = 1'b0;
    pc_wr_en   = 1'b0;
    pc_mux_sel = 2'b00;
    reg_wr_en  = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;
    if (reset_n) begin
      unique case (st)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_wr_en = imem_ack;
        end
        S_EXEC: begin
          pc_wr_en = 1'b1;
          unique case (cls)
            C_BR:  pc_mux_sel = cond_flag ? 2'b01 : 2'b00;
            C_JAL: begin
              reg_wr_en  = 1'b1;
              pc_mux_sel = 2'b10;
            end
            default: reg_wr_en = 1'b1;
          endcase
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (cls == C_ST);
          pc_wr_en = dmem_ack && (cls == C_ST);
        end
        S_WB: begin
          reg_wr_en = 1'b1;
          pc_wr_en  = 1'b1;
        end
        S_HALT:  halted = 1'b1;
        S_FAULT: fault  = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      retired <= '0;
    else if (pc_wr_en) retired <= retired + WIDTH'(1);
  end

endmodule
